data_sram_responder: RTL

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder_if.sv | 33 +++
 rtl/data_sram_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if
// Request/response bus between an initiator (master) and the SRAM-style
// responder (slave).
//   data_sram_en      request valid
//   data_sram_wen     byte write strobes, 4'h0 = read
//   data_sram_size    0 byte, 1 half, 2 word
//   data_sram_addr    byte address
//   data_sram_wdata   write data (lane-replicated by the initiator)
//   data_sram_addr_ok request accepted this cycle when en is also high
//   data_sram_data_ok one-cycle response pulse
//   data_sram_rdata   full-word read data, valid with data_ok, else 0
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_size,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_size,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Fixed-latency SRAM responder with a two-deep in-order response queue.
// Reads capture the RAM word at acceptance; writes update byte lanes at
// acceptance. Every accepted request produces one data_ok pulse exactly
// RESP_LAT cycles after acceptance.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset (queue and flags; RAM is not reset)
//   bus     slave side of data_sram_responder_if
//   mem_err sticky misaligned-access flag
module data_sram_responder #(
    parameter int MEM_AW   = 10,
    parameter int RESP_LAT = 2,
    parameter int QDEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  bus,
    output logic                  mem_err
);

    localparam int          DEPTH  = 2 ** MEM_AW;
    localparam logic [2:0]  LOAD   = 3'(RESP_LAT - 1);
    localparam logic [1:0]  QDEPTH_L = 2'(QDEPTH);

    // State value doubles as the queue occupancy.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [1:0]   count;

    logic [2:0]   cd_reg   [2];
    logic [2:0]   cd_next  [2];
    logic [2:0]   cd_dec   [2];
    logic [31:0]  data_reg [2];
    logic [31:0]  data_next[2];
    logic         mem_err_reg;

    logic         head_done;
    logic         addr_ok;
    logic         push;
    logic         pop;
    logic         is_write;
    logic         misaligned;
    logic         slot;
    logic [MEM_AW-1:0] idx;
    logic [31:0]  ram_word;
    logic [31:0]  new_data;
    logic         unused_addr_bits;

    assign count = state_reg;

    // Head issues data_ok this cycle; a push may refill the freed slot.
    assign head_done = (state_reg != IDLE) && (cd_reg[0] == 3'd0);
    // Gated by resetn so addr_ok is low throughout reset; independent of en.
    assign addr_ok   = resetn && ((count < QDEPTH_L) || head_done);
    assign push      = bus.data_sram_en && addr_ok;
    assign pop       = head_done;

    assign is_write   = |bus.data_sram_wen;
    assign misaligned = ((bus.data_sram_size == 2'd2) && (bus.data_sram_addr[1:0] != 2'b00)) ||
                        ((bus.data_sram_size == 2'd1) && bus.data_sram_addr[0]);
    // Upper address bits alias onto the RAM.
    assign idx              = bus.data_sram_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^bus.data_sram_addr[31:MEM_AW+2];

    // One RAM per byte lane so each strobe writes an independent array.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (push && bus.data_sram_wen[gi] && !misaligned)
                    lane_mem[idx] <= bus.data_sram_wdata[gi*8 +: 8];
            end
            // Read sees only writes from earlier edges: write-before-read order.
            assign ram_word[gi*8 +: 8] = lane_mem[idx];
        end

        for (gi = 0; gi < 2; gi++) begin : g_dec
            assign cd_dec[gi] = (cd_reg[gi] == 3'd0) ? 3'd0 : cd_reg[gi] - 3'd1;
        end
    endgenerate

    assign new_data = (is_write || misaligned) ? 32'h0 : ram_word;

    // Occupancy after this cycle's pop selects where a push lands.
    always_comb begin
        slot = 1'b0;
        case (state_reg)
            IDLE:    slot = 1'b0;
            BUSY:    slot = !pop;
            FULL:    slot = 1'b1;
            default: slot = 1'b0;
        endcase
    end

    // FSM next state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (push) state_next = BUSY;
            BUSY: begin
                if (push && !pop)      state_next = FULL;
                else if (!push && pop) state_next = IDLE;
            end
            FULL: if (!push && pop) state_next = BUSY;
            default: state_next = IDLE;
        endcase
    end

    // Queue next: all countdowns tick, pop shifts entry 1 forward.
    always_comb begin
        cd_next[0]   = cd_dec[0];
        cd_next[1]   = cd_dec[1];
        data_next[0] = data_reg[0];
        data_next[1] = data_reg[1];
        if (pop) begin
            cd_next[0]   = cd_dec[1];
            data_next[0] = data_reg[1];
        end
        if (push) begin
            if (slot) begin
                cd_next[1]   = LOAD;
                data_next[1] = new_data;
            end else begin
                cd_next[0]   = LOAD;
                data_next[0] = new_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            mem_err_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cd_reg[i]   <= 3'd0;
                data_reg[i] <= 32'h0;
            end
        end else begin
            state_reg <= state_next;
            if (push && misaligned)
                mem_err_reg <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                cd_reg[i]   <= cd_next[i];
                data_reg[i] <= data_next[i];
            end
        end
    end

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = head_done;
    assign bus.data_sram_rdata   = head_done ? data_reg[0] : 32'h0;
    assign mem_err               = mem_err_reg;

endmodule
